// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock supervisor and reset sequencer.
// Optional lock-loss counter is enabled with LOCK_LOSS_CNT_EN.
package pll_seq_pkg;

    localparam int LOSS_CNT_W  = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_CLR    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_LOST   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/cc_sync2.sv
// Multi-flop synchronizer for one asynchronous PLL status bit.
module cc_sync2
    import pll_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL lock supervisor: sequences steady-lock reset, user reset and status LED.
// Define LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module pll_rst_sequencer
    import pll_seq_pkg::*;
#(
    parameter int STABLE_CYCLES   = 1024,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int STDY_RST_CYCLES = 4,
    parameter int TMR_W           = 20,
    parameter int LED_BIT         = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       pll_lock_stdy,
    output logic       stdy_rst,
    output logic       dut_rst,
    output logic       timeout_err,
    output logic [2:0] state_o,
    output logic       led
`ifdef LOCK_LOSS_CNT_EN
   ,output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'(STDY_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);

    logic             lock_s;
    logic             stdy_s;
    logic             ok;
    state_t           state;
    state_t           next_state;
    logic [TMR_W-1:0] timer;
    logic [LED_BIT:0] hb;

    cc_sync2 u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    cc_sync2 u_sync_stdy (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock_stdy),
        .q   (stdy_s)
    );

    assign ok = lock_s & stdy_s;

    // Lock presence takes priority over the timer in both WAIT and STABLE.
    always_comb begin
        next_state = state;
        unique case (state)
            S_CLR:    if (timer == CLR_LAST) next_state = S_WAIT;
            S_WAIT: begin
                if (ok)                   next_state = S_STABLE;
                else if (timer == TO_LAST) next_state = S_ERR;
            end
            S_STABLE: begin
                if (!ok)                   next_state = S_WAIT;
                else if (timer == STB_LAST) next_state = S_RUN;
            end
            S_RUN:    if (!ok) next_state = S_LOST;
            S_LOST:   next_state = S_CLR;
            S_ERR:    next_state = S_CLR;
            default:  next_state = S_CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLR;
            timer       <= '0;
            hb          <= '0;
            dut_rst     <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state   <= next_state;
            timer   <= (next_state != state) ? '0 : timer + 1'b1;
            hb      <= hb + 1'b1;
            dut_rst <= (next_state != S_RUN);
            if (next_state == S_ERR) timeout_err <= 1'b1;
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            lock_loss_cnt <= '0;
        else if (state == S_RUN && next_state == S_LOST && lock_loss_cnt != '1)
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
`endif

    assign stdy_rst = (state == S_CLR);
    assign state_o  = state;

    always_comb begin
        led = 1'b0;
        if (timeout_err)
            led = 1'b1;
        else if (state == S_RUN)
            led = hb[LED_BIT];
        else if (state == S_WAIT || state == S_STABLE)
            led = hb[LED_BIT-3];
    end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Self-checking bench for pll_rst_sequencer with a cycle-level reference model.
module tb_pll_rst_sequencer;

    localparam int SC = 8;
    localparam int TO = 32;
    localparam int SR = 4;
    localparam int LB = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_lock_stdy = 1'b0;
    logic       stdy_rst;
    logic       dut_rst;
    logic       timeout_err;
    logic [2:0] state_o;
    logic       led;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_rst_sequencer #(
        .STABLE_CYCLES   (SC),
        .LOCK_TIMEOUT    (TO),
        .STDY_RST_CYCLES (SR),
        .TMR_W           (20),
        .LED_BIT         (LB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .pll_lock_stdy (pll_lock_stdy),
        .stdy_rst      (stdy_rst),
        .dut_rst       (dut_rst),
        .timeout_err   (timeout_err),
        .state_o       (state_o),
        .led           (led)
`ifdef LOCK_LOSS_CNT_EN
       ,.lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // Reference model: state number, cycles spent in it, edges since reset,
    // and the input history seen through two sampling delays.
    int m_st = 0;
    int m_age = 0;
    int m_hb = 0;
    int m_loss = 0;
    bit m_terr = 0;
    bit m_dut = 1;
    bit l1 = 0, l2 = 0, s1 = 0, s2 = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_age = 0; m_hb = 0; m_loss = 0;
            m_terr = 0; m_dut = 1;
            l1 = 0; l2 = 0; s1 = 0; s2 = 0;
        end else begin
            bit ok;
            int ns;
            ok = l2 && s2;
            ns = m_st;
            case (m_st)
                0: if (m_age == SR - 1) ns = 1;
                1: if (ok) ns = 2; else if (m_age == TO - 1) ns = 5;
                2: if (!ok) ns = 1; else if (m_age == SC - 1) ns = 3;
                3: if (!ok) ns = 4;
                default: ns = 0;
            endcase
            if (m_st == 3 && ns == 4 && m_loss < 255) m_loss++;
            if (ns == 5) m_terr = 1;
            m_dut = (ns != 3);
            m_age = (ns != m_st) ? 0 : m_age + 1;
            m_st = ns;
            m_hb = (m_hb + 1) % (1 << (LB + 1));
            l2 = l1; l1 = pll_lock;
            s2 = s1; s1 = pll_lock_stdy;
        end
    end

    function automatic bit exp_led();
        if (m_terr) return 1'b1;
        if (m_st == 3) return 1'(m_hb >> LB);
        if (m_st == 1 || m_st == 2) return 1'(m_hb >> (LB - 3));
        return 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_lock = 1'b0;
        pll_lock_stdy = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_lock = 1'b1;
        pll_lock_stdy = 1'b1;
        tick(3);
        checks++;
        if (state_o !== 3'd0) begin
            errs++; $display("FAIL reset_state got=%0d want=0", state_o);
        end
        checks++;
        if (dut_rst !== 1'b1 || stdy_rst !== 1'b1) begin
            errs++; $display("FAIL reset_rsts got=%b%b want=11", dut_rst, stdy_rst);
        end
        checks++;
        if (timeout_err !== 1'b0 || led !== 1'b0) begin
            errs++; $display("FAIL reset_terr_led got=%b%b want=00", timeout_err, led);
        end
        rst = 1'b0;
    endtask

    task automatic test_acquire();
        int n;
        int hi;
        do_reset();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (stdy_rst === 1'b1 && i < 4) hi++;
            if (stdy_rst === 1'b1 && i >= 4) hi += 100;
            tick(1);
        end
        checks++;
        if (hi != 4) begin
            errs++; $display("FAIL acq_stdy_rst got=%0d want=4", hi);
        end
        pll_lock = 1'b1;
        pll_lock_stdy = 1'b1;
        n = 0;
        while (dut_rst === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != SC + 3) begin
            errs++; $display("FAIL acq_latency got=%0d want=%0d", n, SC + 3);
        end
        checks++;
        if (state_o !== 3'd3) begin
            errs++; $display("FAIL acq_state got=%0d want=3", state_o);
        end
    endtask

    task automatic test_glitch();
        int n;
        bit saw_wait;
        bit early;
        do_reset();
        pll_lock = 1'b1;
        pll_lock_stdy = 1'b1;
        n = 0;
        while (!(m_st == 2 && m_age == 5) && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errs++; $display("FAIL glitch_reach_stable got=timeout want=stable_t5");
        end
        pll_lock = 1'b0;
        saw_wait = 0;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (state_o === 3'd1) saw_wait = 1;
            if (dut_rst !== 1'b1) early = 1;
        end
        pll_lock = 1'b1;
        n = 0;
        while (dut_rst === 1'b1 && n < 60) begin
            tick(1);
            n++;
            if (state_o === 3'd1) saw_wait = 1;
        end
        checks++;
        if (!saw_wait) begin
            errs++; $display("FAIL glitch_wait got=no_wait want=wait");
        end
        checks++;
        if (early) begin
            errs++; $display("FAIL glitch_dut_rst got=0 want=1");
        end
        checks++;
        if (n != SC + 3) begin
            errs++; $display("FAIL glitch_recount got=%0d want=%0d", n, SC + 3);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (state_o !== 3'd1 && n < 20) begin
            tick(1);
            n++;
        end
        n = 0;
        while (state_o !== 3'd5 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != TO) begin
            errs++; $display("FAIL to_wait_cycles got=%0d want=%0d", n, TO);
        end
        checks++;
        if (timeout_err !== 1'b1 || led !== 1'b1) begin
            errs++; $display("FAIL to_err_led got=%b%b want=11", timeout_err, led);
        end
        tick(1);
        checks++;
        if (state_o !== 3'd0 || stdy_rst !== 1'b1) begin
            errs++; $display("FAIL to_retry_clr got=%0d/%b want=0/1", state_o, stdy_rst);
        end
        tick(4);
        checks++;
        if (state_o !== 3'd1) begin
            errs++; $display("FAIL to_retry_wait got=%0d want=1", state_o);
        end
        pll_lock = 1'b1;
        pll_lock_stdy = 1'b1;
        n = 0;
        while (dut_rst === 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (state_o !== 3'd3 || timeout_err !== 1'b1 || led !== 1'b1) begin
            errs++;
            $display("FAIL to_run_sticky got=%0d/%b/%b want=3/1/1", state_o, timeout_err, led);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        int hi;
        do_reset();
        pll_lock = 1'b1;
        pll_lock_stdy = 1'b1;
        n = 0;
        while (dut_rst === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        pll_lock = 1'b0;
        tick(2);
        checks++;
        if (dut_rst !== 1'b0) begin
            errs++; $display("FAIL loss_early got=%b want=0", dut_rst);
        end
        tick(1);
        checks++;
        if (dut_rst !== 1'b1 || state_o !== 3'd4) begin
            errs++; $display("FAIL loss_edge3 got=%b/%0d want=1/4", dut_rst, state_o);
        end
        tick(1);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (stdy_rst === 1'b1) hi++;
            tick(1);
        end
        checks++;
        if (hi != SR) begin
            errs++; $display("FAIL loss_stdy_rst got=%0d want=%0d", hi, SR);
        end
`ifdef LOCK_LOSS_CNT_EN
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            errs++; $display("FAIL loss_cnt got=%0d want=1", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_rst_mid();
        int n;
        do_reset();
        pll_lock = 1'b1;
        pll_lock_stdy = 1'b1;
        n = 0;
        while (!(m_st == 2 && m_age == 3) && n < 60) begin
            tick(1);
            n++;
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (state_o !== 3'd0 || dut_rst !== 1'b1 || stdy_rst !== 1'b1) begin
            errs++;
            $display("FAIL mid_rst got=%0d/%b/%b want=0/1/1", state_o, dut_rst, stdy_rst);
        end
        rst = 1'b0;
        n = 0;
        while (dut_rst === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != SR + 1 + SC) begin
            errs++; $display("FAIL mid_recount got=%0d want=%0d", n, SR + 1 + SC);
        end
    endtask

    task automatic test_random();
        int seg;
        logic [6:0] got;
        logic [6:0] exp;
        do_reset();
        seg = 0;
        for (int i = 0; i < 1500; i++) begin
            got = {state_o, dut_rst, stdy_rst, timeout_err, led};
            exp = {3'(m_st), m_dut, (m_st == 0), m_terr, exp_led()};
            checks++;
            if (got !== exp) begin
                errs++; $display("FAIL rand_cyc%0d got=%b want=%b", i, got, exp);
            end
            if (seg == 0) begin
                seg = $urandom_range(1, 40);
                pll_lock = ($urandom_range(0, 9) < 7);
                pll_lock_stdy = ($urandom_range(0, 9) < 8);
                rst = ($urandom_range(0, 49) == 0);
            end else begin
                seg--;
                rst = 1'b0;
            end
            tick(1);
        end
        rst = 1'b0;
    endtask

`ifdef LOCK_LOSS_CNT_EN
    task automatic test_saturate();
        int n;
        bit stuck;
        do_reset();
        stuck = 0;
        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b1;
            pll_lock_stdy = 1'b1;
            n = 0;
            while (dut_rst === 1'b1 && n < 60) begin
                tick(1);
                n++;
            end
            if (n >= 60) stuck = 1;
            pll_lock = 1'b0;
            tick(5);
        end
        checks++;
        if (stuck) begin
            errs++; $display("FAIL sat_reach_run got=timeout want=run");
        end
        checks++;
        if (lock_loss_cnt !== 8'd255 || m_loss != 255) begin
            errs++; $display("FAIL sat_cnt got=%0d want=255", lock_loss_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_acquire();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_rst_mid();
        test_random();
`ifdef LOCK_LOSS_CNT_EN
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
